regs_issue_ctrl: RTL and testbench

//  Decode/issue front end feeding regs_bank: latches fetched instruction, drives read ports inpA/inpB.

---
 rtl/regs_issue_pkg.sv | 50 +++++
 rtl/regs_issue_ctrl_scoreboard.sv | 55 +++++
 rtl/regs_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_regs_issue_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regs_issue_pkg.sv
// Shared instruction layout, opcode classes, regs_bank commands and FSM states
// for the regs_issue_ctrl decode/issue front end.
package regs_issue_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_FW  = 4;
  localparam int unsigned REG_FW  = 4;
  localparam int unsigned IMM_W   = 16;
  localparam int unsigned CTRL_W  = 3;

  // Opcode map: 1..9 reg-reg, A reg-imm, B/C no destination, D link, 0/E/F nop
  localparam logic [OPC_FW-1:0] OPC_NOP    = 4'h0;
  localparam logic [OPC_FW-1:0] OPC_RR_1ST = 4'h1;
  localparam logic [OPC_FW-1:0] OPC_RR_LST = 4'h9;
  localparam logic [OPC_FW-1:0] OPC_RI     = 4'hA;
  localparam logic [OPC_FW-1:0] OPC_RS2_RD = 4'hB;
  localparam logic [OPC_FW-1:0] OPC_RS1_RD = 4'hC;
  localparam logic [OPC_FW-1:0] OPC_LINK   = 4'hD;

  localparam logic [CTRL_W-1:0] RB_NOP  = 3'b000;
  localparam logic [CTRL_W-1:0] RB_WR   = 3'b001;
  localparam logic [CTRL_W-1:0] RB_LINK = 3'b011;

  typedef struct packed {
    logic [OPC_FW-1:0] opc;
    logic [REG_FW-1:0] rd;
    logic [REG_FW-1:0] rs1;
    logic [REG_FW-1:0] rs2;
    logic [IMM_W-1:0]  imm;
  } instr_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HOLD  = 2'd1,
    ST_STALL = 2'd2
  } issue_state_e;

  function automatic logic is_nop(input logic [OPC_FW-1:0] opc);
    return (opc == OPC_NOP) || (opc > OPC_LINK);
  endfunction

  function automatic logic writes_rd(input logic [OPC_FW-1:0] opc);
    return ((opc >= OPC_RR_1ST) && (opc <= OPC_RI)) || (opc == OPC_LINK);
  endfunction

  function automatic logic reads_rs2(input logic [OPC_FW-1:0] opc);
    return ((opc >= OPC_RR_1ST) && (opc <= OPC_RR_LST)) || (opc == OPC_RS2_RD);
  endfunction

endpackage

// File: rtl/regs_issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on writeback.
// DECODE_WB_BYPASS_EN: a same-cycle writeback masks its bit out of the hazard check.
module issue_scoreboard #(
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              set_i,
  input  logic [REG_AW-1:0] set_idx_i,
  input  logic              clr_i,
  input  logic [REG_AW-1:0] clr_idx_i,
  input  logic              chk_rs1_i,
  input  logic              chk_rs2_i,
  input  logic              chk_rd_i,
  input  logic [REG_AW-1:0] rs1_i,
  input  logic [REG_AW-1:0] rs2_i,
  input  logic [REG_AW-1:0] rd_i,
  output logic              hazard_c_o
);

  localparam int unsigned NREG = 2 ** REG_AW;

  logic [NREG-1:0] sb_q;
  logic [NREG-1:0] sb_d;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] sb_eff;

  // Clear applied first so a same-cycle set of the same bit wins
  always_comb begin
    clr_mask = clr_i ? (NREG'(1) << clr_idx_i) : '0;
    sb_d     = sb_q & ~clr_mask;
    if (set_i) begin
      sb_d[set_idx_i] = 1'b1;
    end
  end

`ifdef DECODE_WB_BYPASS_EN
  assign sb_eff = sb_q & ~clr_mask;
`else
  assign sb_eff = sb_q;
`endif

  assign hazard_c_o = (chk_rs1_i & sb_eff[rs1_i]) |
                      (chk_rs2_i & sb_eff[rs2_i]) |
                      (chk_rd_i  & sb_eff[rd_i]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

endmodule

// File: rtl/regs_issue_ctrl.sv
// Decode/issue front end for regs_bank: holds one instruction, stalls on RAW/WAW
// via the scoreboard, routes writebacks. Optional macro: DECODE_WB_BYPASS_EN.
module regs_issue_ctrl
  import regs_issue_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned OPC_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0] in_pc,
  input  logic              flush,
  input  logic              wb_valid,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_link,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] wb_pc,
  output logic [REG_AW-1:0] inpA,
  output logic [REG_AW-1:0] inpB,
  output logic [REG_AW-1:0] inpC,
  output logic [2:0]        control,
  output logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OPC_W-1:0]  out_opcode,
  output logic [REG_AW-1:0] out_rd,
  output logic [DATA_W-1:0] out_imm,
  output logic [DATA_W-1:0] out_pc
);

  issue_state_e      state_q, state_d;
  instr_t            instr_q, instr_d;
  logic [DATA_W-1:0] pc_q, pc_d;
  logic              hazard;
  logic              issue;
  logic              load;
  logic              rd_wr;

  assign rd_wr = writes_rd(instr_q.opc);
  assign issue = out_valid & out_ready;

  issue_scoreboard #(.REG_AW(REG_AW)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .set_i      (issue & rd_wr),
    .set_idx_i  (REG_AW'(instr_q.rd)),
    .clr_i      (wb_valid),
    .clr_idx_i  (wb_rd),
    .chk_rs1_i  (~is_nop(instr_q.opc)),
    .chk_rs2_i  (reads_rs2(instr_q.opc)),
    .chk_rd_i   (rd_wr),
    .rs1_i      (REG_AW'(instr_q.rs1)),
    .rs2_i      (REG_AW'(instr_q.rs2)),
    .rd_i       (REG_AW'(instr_q.rd)),
    .hazard_c_o (hazard)
  );

  // A stalled instruction whose hazard has cleared behaves exactly like HOLD
  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    pc_d      = pc_q;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    load      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        in_ready = ~flush;
        if (in_valid && !flush) begin
          load    = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD, ST_STALL: begin
        if (hazard) begin
          state_d = ST_STALL;
        end else begin
          out_valid = 1'b1;
          in_ready  = ~flush & out_ready;
          if (!out_ready) begin
            state_d = ST_HOLD;
          end else if (in_valid && !flush) begin
            load    = 1'b1;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_EMPTY;
          end
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (flush) begin
      state_d = ST_EMPTY;
    end
    if (load) begin
      instr_d = instr_t'(in_instr[INSTR_W-1:0]);
      pc_d    = in_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      instr_q <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
    end
  end

  assign inpA       = REG_AW'(instr_q.rs1);
  assign inpB       = REG_AW'(instr_q.rs2);
  assign out_opcode = OPC_W'(instr_q.opc);
  assign out_rd     = REG_AW'(instr_q.rd);
  assign out_imm    = {{(DATA_W-IMM_W){instr_q.imm[IMM_W-1]}}, instr_q.imm};
  assign out_pc     = pc_q;

  // Writeback is a straight combinational pass-through to regs_bank
  assign control = wb_valid ? (wb_link ? RB_LINK : RB_WR) : RB_NOP;
  assign inpC    = wb_rd;
  assign data    = wb_data;
  assign pc      = wb_pc;

endmodule

// File: tb/tb_regs_issue_ctrl.sv
// Self-checking bench for regs_issue_ctrl: directed scenarios plus a randomized run
// against a pending-register / held-instruction reference model.
module tb_regs_issue_ctrl;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned OPC_W  = 4;
`ifdef DECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_instr = '0;
  logic [DATA_W-1:0] in_pc = '0;
  logic              flush = 1'b0;
  logic              wb_valid = 1'b0;
  logic [REG_AW-1:0] wb_rd = '0;
  logic              wb_link = 1'b0;
  logic [DATA_W-1:0] wb_data = '0;
  logic [DATA_W-1:0] wb_pc = '0;
  logic [REG_AW-1:0] inpA, inpB, inpC;
  logic [2:0]        control;
  logic [DATA_W-1:0] data, pc;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [OPC_W-1:0]  out_opcode;
  logic [REG_AW-1:0] out_rd;
  logic [DATA_W-1:0] out_imm, out_pc;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  regs_issue_ctrl #(.DATA_W(DATA_W), .REG_AW(REG_AW), .OPC_W(OPC_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_link(wb_link), .wb_data(wb_data), .wb_pc(wb_pc),
    .inpA(inpA), .inpB(inpB), .inpC(inpC), .control(control), .data(data),
    .pc(pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_imm(out_imm), .out_pc(out_pc)
  );

  // Reference model: is an instruction held, what is it, which registers await writeback
  bit          m_held;
  logic [31:0] m_instr;
  logic [31:0] m_pc;
  bit          m_pend[16];

  function automatic bit m_writes(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd10) || o == 4'd13;
  endfunction

  function automatic bit m_reads2(input logic [3:0] o);
    return (o >= 4'd1 && o <= 4'd9) || o == 4'd11;
  endfunction

  function automatic bit m_reads1(input logic [3:0] o);
    return o >= 4'd1 && o <= 4'd13;
  endfunction

  function automatic bit m_hazard();
    logic [3:0] o, rd, r1, r2;
    bit busy[16];
    o = m_instr[31:28]; rd = m_instr[27:24]; r1 = m_instr[23:20]; r2 = m_instr[19:16];
    busy = m_pend;
    if (BYP && wb_valid) busy[wb_rd] = 1'b0;
    return m_reads1(o) && (busy[r1] || (m_reads2(o) && busy[r2]) || (m_writes(o) && busy[rd]));
  endfunction

  function automatic bit exp_ov();
    return m_held && !m_hazard();
  endfunction

  function automatic bit exp_ir();
    return !flush && (!m_held || (exp_ov() && out_ready));
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit hs, acc;
    if (!rst_n) begin
      m_held  <= 1'b0;
      m_instr <= '0;
      m_pc    <= '0;
      foreach (m_pend[i]) m_pend[i] <= 1'b0;
    end else begin
      hs  = exp_ov() && out_ready;
      acc = in_valid && exp_ir();
      if (wb_valid) m_pend[wb_rd] <= 1'b0;
      if (hs && m_writes(m_instr[31:28])) m_pend[m_instr[27:24]] <= 1'b1;
      if (flush) m_held <= 1'b0;
      else if (acc) begin
        m_held  <= 1'b1;
        m_instr <= in_instr;
        m_pc    <= in_pc;
      end else if (hs) m_held <= 1'b0;
    end
  end

  function automatic logic [31:0] mk(input logic [3:0] o, input logic [3:0] rd,
                                     input logic [3:0] r1, input logic [3:0] r2,
                                     input logic [15:0] imm);
    return {o, rd, r1, r2, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_link = 1'b0; wb_data = '0; wb_pc = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_checks++; if (control !== 3'b000) begin n_errors++; $display("FAIL reset_control: got %b want 000", control); end
    n_checks++; if ({inpA, inpB, inpC} !== 12'h000) begin n_errors++; $display("FAIL reset_inp: got %h want 000", {inpA, inpB, inpC}); end
    n_checks++; if ({out_opcode, out_rd, out_imm, out_pc} !== 72'h0) begin n_errors++; $display("FAIL reset_outs: got %h want 0", {out_opcode, out_rd, out_imm, out_pc}); end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_issue_raw();
    do_reset();
    in_valid = 1'b1; in_instr = mk(4'h1, 4'd3, 4'd1, 4'd2, 16'h8001); in_pc = 32'h100;
    @(negedge clk);
    n_checks++; if ({in_ready, out_valid} !== 2'b10) begin n_errors++; $display("FAIL raw_load: got ir/ov %b want 10", {in_ready, out_valid}); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({out_valid, inpA, inpB, out_rd, out_opcode, in_ready} !== {1'b1, 4'd1, 4'd2, 4'd3, 4'd1, 1'b0})
      begin n_errors++; $display("FAIL raw_decode: got %h", {out_valid, inpA, inpB, out_rd, out_opcode, in_ready}); end
    n_checks++; if (out_imm !== 32'hFFFF8001) begin n_errors++; $display("FAIL raw_imm: got %h want ffff8001", out_imm); end
    n_checks++; if (out_pc !== 32'h100) begin n_errors++; $display("FAIL raw_pc: got %h want 100", out_pc); end
    tick();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = mk(4'h1, 4'd4, 4'd3, 4'd0, 16'h0005); in_pc = 32'h104;
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b11) begin n_errors++; $display("FAIL raw_b2b: got ov/ir %b want 11", {out_valid, in_ready}); end
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if ({out_valid, in_ready, inpA} !== {2'b00, 4'd3}) begin n_errors++; $display("FAIL raw_stall%0d: got %h want 03", i, {out_valid, in_ready, inpA}); end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 4'd3; wb_link = 1'b0; wb_data = 32'hFFFFFFFF;
    @(negedge clk);
    n_checks++; if ({control, inpC} !== {3'b001, 4'd3}) begin n_errors++; $display("FAIL raw_wb_ctrl: got %h want 13", {control, inpC}); end
    n_checks++; if (data !== 32'hFFFFFFFF) begin n_errors++; $display("FAIL raw_wb_data: got %h want ffffffff", data); end
    n_checks++; if (out_valid !== BYP) begin n_errors++; $display("FAIL raw_wb_cycle_ov: got %b want %b", out_valid, BYP); end
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (control !== 3'b000) begin n_errors++; $display("FAIL raw_ctrl_idle: got %b want 000", control); end
    n_checks++; if (out_valid !== !BYP) begin n_errors++; $display("FAIL raw_after_wb_ov: got %b want %b", out_valid, !BYP); end
    tick();
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_errors++; $display("FAIL raw_drained: got ov/ir %b want 01", {out_valid, in_ready}); end
    idle_inputs();
  endtask

  task automatic test_writeback();
    idle_inputs();
    wb_valid = 1'b1; wb_link = 1'b1; wb_rd = 4'd15; wb_pc = 32'h33333333;
    @(negedge clk);
    n_checks++; if ({control, inpC} !== {3'b011, 4'd15}) begin n_errors++; $display("FAIL wb_link_ctrl: got %h want 3f", {control, inpC}); end
    n_checks++; if (pc !== 32'h33333333) begin n_errors++; $display("FAIL wb_link_pc: got %h want 33333333", pc); end
    tick();
    wb_link = 1'b0; wb_data = 32'hFFFFFFFF;
    @(negedge clk);
    n_checks++; if ({control, data} !== {3'b001, 32'hFFFFFFFF}) begin n_errors++; $display("FAIL wb_write: got %h", {control, data}); end
    tick();
    wb_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (control !== 3'b000) begin n_errors++; $display("FAIL wb_none: got %b want 000", control); end
    tick();
  endtask

  task automatic test_hold_set_wins();
    do_reset();
    in_valid = 1'b1; in_instr = mk(4'h2, 4'd5, 4'd7, 4'd8, 16'h1234); in_pc = 32'h200;
    tick();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = mk(4'h3, 4'd9, 4'd1, 4'd1, 16'hFFFF); in_pc = 32'h300;
      @(negedge clk);
      n_checks++; if ({out_valid, out_opcode, out_rd, inpA, inpB, in_ready} !== {1'b1, 4'd2, 4'd5, 4'd7, 4'd8, 1'b0})
        begin n_errors++; $display("FAIL hold%0d_fields: got %h", i, {out_valid, out_opcode, out_rd, inpA, inpB, in_ready}); end
      n_checks++; if ({out_imm, out_pc} !== {32'h00001234, 32'h200}) begin n_errors++; $display("FAIL hold%0d_imm_pc: got %h", i, {out_imm, out_pc}); end
      tick();
    end
    out_ready = 1'b1; wb_valid = 1'b1; wb_rd = 4'd5;
    in_valid = 1'b1; in_instr = mk(4'hC, 4'd0, 4'd5, 4'd0, 16'h0); in_pc = 32'h204;
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready} !== 2'b11) begin n_errors++; $display("FAIL setwin_issue: got ov/ir %b want 11", {out_valid, in_ready}); end
    tick();
    wb_valid = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if ({out_valid, inpA} !== {1'b0, 4'd5}) begin n_errors++; $display("FAIL setwin_pending%0d: got %h want 05", i, {out_valid, inpA}); end
      tick();
    end
    wb_valid = 1'b1; wb_rd = 4'd5;
    @(negedge clk);
    n_checks++; if (out_valid !== BYP) begin n_errors++; $display("FAIL setwin_release: got %b want %b", out_valid, BYP); end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_instr = mk(4'h1, 4'd9, 4'd0, 4'd0, 16'h0);
    tick();
    out_ready = 1'b1; in_instr = mk(4'h5, 4'd2, 4'd3, 4'd4, 16'h0); in_pc = 32'h400;
    tick();
    out_ready = 1'b0; flush = 1'b1; in_instr = mk(4'h6, 4'd7, 4'd7, 4'd7, 16'h0);
    @(negedge clk);
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    tick();
    flush = 1'b0; in_valid = 1'b1; in_instr = mk(4'h1, 4'd1, 4'd9, 4'd0, 16'h0);
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready, out_opcode} !== {2'b01, 4'd5}) begin n_errors++; $display("FAIL flush_empty: got %h want 15", {out_valid, in_ready, out_opcode}); end
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if ({out_valid, inpA} !== {1'b0, 4'd9}) begin n_errors++; $display("FAIL flush_sb_kept: got %h want 09", {out_valid, inpA}); end
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid_stall();
    do_reset();
    in_valid = 1'b1; in_instr = mk(4'h1, 4'd3, 4'd1, 4'd2, 16'h0); in_pc = 32'h500;
    tick();
    out_ready = 1'b1; in_instr = mk(4'h1, 4'd4, 4'd3, 4'd0, 16'h7); in_pc = 32'h504;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL mid_stall: got %b want 0", out_valid); end
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++; if ({out_valid, in_ready, inpA, inpB, out_opcode, out_rd} !== 18'h10000) begin n_errors++; $display("FAIL mid_reset_state: got %h", {out_valid, in_ready, inpA, inpB, out_opcode, out_rd}); end
    n_checks++; if ({out_imm, out_pc} !== 64'h0) begin n_errors++; $display("FAIL mid_reset_data: got %h", {out_imm, out_pc}); end
    tick();
    rst_n = 1'b1; out_ready = 1'b0;
    in_valid = 1'b1; in_instr = mk(4'hC, 4'd0, 4'd3, 4'd0, 16'h0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (out_valid !== 1'b1) begin n_errors++; $display("FAIL post_reset_sb_clear: got %b want 1", out_valid); end
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    logic [2:0]  exp_ctrl;
    logic [31:0] exp_imm;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_instr  = $urandom();
      in_pc     = $urandom();
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 99) < 3);
      wb_valid  = ($urandom_range(0, 9) < 4);
      wb_rd     = REG_AW'($urandom_range(0, 15));
      wb_link   = 1'($urandom_range(0, 1));
      wb_data   = $urandom();
      wb_pc     = $urandom();
      @(negedge clk);
      exp_ctrl = wb_valid ? (wb_link ? 3'b011 : 3'b001) : 3'b000;
      exp_imm  = {{16{m_instr[15]}}, m_instr[15:0]};
      n_checks++; if (out_valid !== exp_ov()) begin n_errors++; $display("FAIL rnd_out_valid c%0d: got %b want %b", c, out_valid, exp_ov()); end
      n_checks++; if (in_ready !== exp_ir()) begin n_errors++; $display("FAIL rnd_in_ready c%0d: got %b want %b", c, in_ready, exp_ir()); end
      n_checks++; if ({out_opcode, out_rd, inpA, inpB} !== m_instr[31:16]) begin n_errors++; $display("FAIL rnd_fields c%0d: got %h want %h", c, {out_opcode, out_rd, inpA, inpB}, m_instr[31:16]); end
      n_checks++; if ({out_imm, out_pc} !== {exp_imm, m_pc}) begin n_errors++; $display("FAIL rnd_imm_pc c%0d: got %h want %h", c, {out_imm, out_pc}, {exp_imm, m_pc}); end
      n_checks++; if ({control, inpC, data, pc} !== {exp_ctrl, wb_rd, wb_data, wb_pc}) begin n_errors++; $display("FAIL rnd_wb c%0d: got %h want %h", c, {control, inpC, data, pc}, {exp_ctrl, wb_rd, wb_data, wb_pc}); end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_issue_raw();
    test_writeback();
    test_hold_set_wins();
    test_flush();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
